// File: rtl/cmd_rr_arbiter_if.sv
// Command-path bundle between the command sources (master side) and the
// round-robin arbiter (slave side), including the command-buffer outputs.
interface cmd_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 256,
  parameter int ID_W    = 4
);
  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ*CMD_W-1:0] req_payload_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     cmd_buf_alfull_in;
  logic                     command_valid_out;
  logic [CMD_W-1:0]         command_payload_out;
  logic [ID_W-1:0]          command_id_out;

  modport slave (
    input  req_valid_in, req_payload_in, cmd_buf_alfull_in,
    output req_ready_out, command_valid_out, command_payload_out, command_id_out
  );

  modport master (
    output req_valid_in, req_payload_in, cmd_buf_alfull_in,
    input  req_ready_out, command_valid_out, command_payload_out, command_id_out
  );
endinterface

// File: rtl/cmd_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_REQ command sources, each with a one-entry
// holding register, onto the single AFU command-buffer port.
module cmd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 256,
  parameter int ID_W    = 4
) (
  input  logic            clock,
  input  logic            rstn,
  input  logic            enabled_in,
  cmd_rr_arbiter_if.slave bus,
  output logic [31:0]     issued_count_out,
  output logic            idle_out
);

  typedef enum logic [1:0] {
    ARB_RESET = 2'd0,
    ARB_RUN   = 2'd1,
    ARB_PAUSE = 2'd2
  } arb_state_e;

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] hold_valid_q, hold_valid_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [CMD_W-1:0]   hold_q [NUM_REQ];
  logic [CMD_W-1:0]   hold_d [NUM_REQ];
  logic               cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]   cmd_payload_q, cmd_payload_d;
  logic [ID_W-1:0]    cmd_id_q, cmd_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [31:0]        issued_q, issued_d;

  logic [NUM_REQ-1:0] accept_s;
  logic [NUM_REQ-1:0] rot_s;
  logic               found_s;
  logic               grant_s;
  logic [ID_W-1:0]    winner_s;

  // Run/pause sequencing; holds keep filling while paused.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_RESET: state_d = ARB_RUN;
      ARB_RUN: begin
        if (!enabled_in) state_d = ARB_PAUSE;
        else             state_d = ARB_RUN;
      end
      ARB_PAUSE: begin
        if (enabled_in) state_d = ARB_RUN;
        else            state_d = ARB_PAUSE;
      end
      default: state_d = ARB_RESET;
    endcase
  end

  // Rotate so bit 0 is the slot after the last winner; the first set bit wins.
  always_comb begin
    rot_s    = NUM_REQ'({hold_valid_q, hold_valid_q} >> (int'(rr_ptr_q) + 1));
    found_s  = 1'b0;
    winner_s = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found_s && rot_s[j]) begin
        found_s  = 1'b1;
        winner_s = ID_W'((int'(rr_ptr_q) + 1 + j) % NUM_REQ);
      end else begin
        found_s  = found_s;
      end
    end
  end

  assign grant_s  = (state_q == ARB_RUN) && enabled_in && !bus.cmd_buf_alfull_in && found_s;
  assign accept_s = bus.req_valid_in & ready_q & {NUM_REQ{state_q != ARB_RESET}};

  // Hold registers, output command and bookkeeping for the next edge.
  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_d        = hold_q;
    cmd_valid_d   = 1'b0;
    cmd_payload_d = cmd_payload_q;
    cmd_id_d      = cmd_id_q;
    rr_ptr_d      = rr_ptr_q;
    issued_d      = issued_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s && (winner_s == ID_W'(i))) begin
        hold_valid_d[i] = 1'b0;
        cmd_payload_d   = hold_q[i];
      end else if (accept_s[i]) begin
        hold_valid_d[i] = 1'b1;
        hold_d[i]       = bus.req_payload_in[i*CMD_W +: CMD_W];
      end else begin
        hold_valid_d[i] = hold_valid_q[i];
      end
    end
    if (grant_s) begin
      cmd_valid_d = 1'b1;
      cmd_id_d    = winner_s;
      rr_ptr_d    = winner_s;
      issued_d    = issued_q + 32'd1;
    end else begin
      cmd_valid_d = 1'b0;
    end
    // Ready is registered, so a hold cannot refill on the edge that empties it.
    ready_d = ~hold_valid_d;
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q       <= ARB_RESET;
      hold_valid_q  <= '0;
      ready_q       <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_payload_q <= '0;
      cmd_id_q      <= '0;
      rr_ptr_q      <= ID_W'(NUM_REQ - 1);
      issued_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      ready_q       <= ready_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_payload_q <= cmd_payload_d;
      cmd_id_q      <= cmd_id_d;
      rr_ptr_q      <= rr_ptr_d;
      issued_q      <= issued_d;
    end
  end

  // Hold payloads are qualified by hold_valid and need no reset.
  always_ff @(posedge clock) begin
    hold_q <= hold_d;
  end

  assign bus.req_ready_out       = ready_q;
  assign bus.command_valid_out   = cmd_valid_q;
  assign bus.command_payload_out = cmd_payload_q;
  assign bus.command_id_out      = cmd_id_q;
  assign issued_count_out        = issued_q;
  assign idle_out                = (hold_valid_q == '0) && !cmd_valid_q;

endmodule

// File: tb/tb_cmd_rr_arbiter.sv
// Self-checking bench for cmd_rr_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_cmd_rr_arbiter;
  localparam int NR = 4;
  localparam int CW = 32;
  localparam int IW = 4;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        en   = 1'b0;
  logic [31:0] issued;
  logic        idle;

  cmd_rr_arbiter_if #(.NUM_REQ(NR), .CMD_W(CW), .ID_W(IW)) bus ();

  cmd_rr_arbiter #(.NUM_REQ(NR), .CMD_W(CW), .ID_W(IW)) dut (
    .clock            (clk),
    .rstn             (rstn),
    .enabled_in       (en),
    .bus              (bus),
    .issued_count_out (issued),
    .idle_out         (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pl_of(input int i);
    return 32'hA5A5_0000 + CW'(i);
  endfunction

  // Payload on the output follows the id, except before any grant since reset.
  task automatic check_out(input string tag, input logic vo, input logic [3:0] id,
                           input logic [3:0] rdy, input logic [31:0] iss, input logic idl);
    logic [CW-1:0] epl;
    epl = (iss == 32'd0) ? 32'd0 : pl_of(int'(id));
    chk({tag, "/valid"},   64'(bus.command_valid_out),   64'(vo));
    chk({tag, "/id"},      64'(bus.command_id_out),      64'(id));
    chk({tag, "/payload"}, 64'(bus.command_payload_out), 64'(epl));
    chk({tag, "/ready"},   64'(bus.req_ready_out),       64'(rdy));
    chk({tag, "/issued"},  64'(issued),                  64'(iss));
    chk({tag, "/idle"},    64'(idle),                    64'(idl));
  endtask

  task automatic set_in(input logic r, input logic e, input logic a, input logic [3:0] v);
    rstn                  = r;
    en                    = e;
    bus.cmd_buf_alfull_in = a;
    bus.req_valid_in      = v;
  endtask

  // ---------------- behavioural reference model ----------------
  logic          m_live, m_run, m_ov;
  logic [3:0]    m_hv, m_rdy;
  logic [CW-1:0] m_hold [NR];
  logic [CW-1:0] m_opl;
  logic [31:0]   m_cnt;
  int            m_ptr, m_oid, m_w, m_j;

  always @(posedge clk) begin
    if (!rstn) begin
      m_live = 1'b0; m_run = 1'b0; m_ov = 1'b0;
      m_hv   = 4'd0; m_rdy = 4'd0;
      m_ptr  = NR - 1; m_oid = 0; m_opl = '0; m_cnt = 32'd0;
    end else begin
      m_w = -1;
      if (m_run && en && !bus.cmd_buf_alfull_in) begin
        for (int k = 1; k <= NR; k++) begin
          m_j = (m_ptr + k) % NR;
          if (m_w < 0 && m_hv[2'(m_j)]) m_w = m_j;
        end
      end
      if (m_w >= 0) begin
        m_ov  = 1'b1;
        m_oid = m_w;
        m_opl = m_hold[2'(m_w)];
        m_hv[2'(m_w)] = 1'b0;
        m_ptr = m_w;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_ov = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid_in[i] && m_rdy[i]) begin
          m_hv[i]   = 1'b1;
          m_hold[i] = bus.req_payload_in[i*CW +: CW];
        end
      end
      m_rdy  = ~m_hv;
      m_run  = m_live ? en : 1'b1;
      m_live = 1'b1;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        r, e, a;
    logic [3:0]  v;
    logic        vo;
    logic [3:0]  id;
    logic [3:0]  rdy;
    logic [31:0] iss;
    logic        idl;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic r, input logic e, input logic a, input logic [3:0] v,
                              input logic vo, input logic [3:0] id, input logic [3:0] rdy,
                              input logic [31:0] iss, input logic idl);
    vec_t t;
    t.r = r; t.e = e; t.a = a; t.v = v; t.vo = vo; t.id = id; t.rdy = rdy; t.iss = iss; t.idl = idl;
    return t;
  endfunction

  logic [3:0]    drv_v, acc;
  logic [CW-1:0] pl [NR];

  initial begin
    // reset, then all four at once granted in index order
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000, 32'd0, 1'b1);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b0000, 32'd0, 1'b1);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 4'b1111, 32'd0, 1'b1);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 4'b1111, 1'b0, 4'd0, 4'b0000, 32'd0, 1'b0);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd0, 4'b0001, 32'd1, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd1, 4'b0011, 32'd2, 1'b0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd2, 4'b0111, 32'd3, 1'b0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd3, 4'b1111, 32'd4, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd3, 4'b1111, 32'd4, 1'b1);
    // paused while 1 and 3 are accepted; one pause-to-run cycle before grants
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, 4'd3, 4'b0101, 32'd4, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'd3, 4'b0101, 32'd4, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd3, 4'b0101, 32'd4, 1'b0);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd1, 4'b0111, 32'd5, 1'b0);
    tbl[13] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd3, 4'b1111, 32'd6, 1'b0);
    tbl[14] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd3, 4'b1111, 32'd6, 1'b1);
    // almost-full for five cycles with hold 2 full
    tbl[15] = mk(1'b1, 1'b1, 1'b0, 4'b0100, 1'b0, 4'd3, 4'b1011, 32'd6, 1'b0);
    for (int i = 16; i <= 20; i++)
      tbl[i] = mk(1'b1, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd3, 4'b1011, 32'd6, 1'b0);
    tbl[21] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd2, 4'b1111, 32'd7, 1'b0);
    tbl[22] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd2, 4'b1111, 32'd7, 1'b1);

    bus.req_valid_in      = 4'd0;
    bus.cmd_buf_alfull_in = 1'b0;
    for (int i = 0; i < NR; i++) bus.req_payload_in[i*CW +: CW] = pl_of(i);
    @(negedge clk);

    for (int r = 0; r < 23; r++) begin
      set_in(tbl[r].r, tbl[r].e, tbl[r].a, tbl[r].v);
      @(negedge clk);
      check_out($sformatf("vec%0d", r), tbl[r].vo, tbl[r].id, tbl[r].rdy, tbl[r].iss, tbl[r].idl);
    end

    // two requesters always valid with the pointer parked on 3: strict alternation
    set_in(1'b1, 1'b1, 1'b0, 4'b1000); @(negedge clk);
    chk("alt_pre/valid", 64'(bus.command_valid_out), 64'd0);
    set_in(1'b1, 1'b1, 1'b0, 4'b0000); @(negedge clk);
    check_out("alt_ptr3", 1'b1, 4'd3, 4'b1111, 32'd8, 1'b0);
    set_in(1'b1, 1'b1, 1'b0, 4'b1001);
    @(negedge clk);
    chk("alt_fill/valid", 64'(bus.command_valid_out), 64'd0);
    for (int s = 2; s <= 9; s++) begin
      @(negedge clk);
      chk($sformatf("alt%0d/valid", s), 64'(bus.command_valid_out), 64'd1);
      chk($sformatf("alt%0d/id", s), 64'(bus.command_id_out), (s % 2 == 0) ? 64'd0 : 64'd3);
    end
    set_in(1'b1, 1'b1, 1'b0, 4'b0000); @(negedge clk);
    check_out("alt_drain", 1'b1, 4'd0, 4'b1111, 32'd17, 1'b0);
    @(negedge clk);
    check_out("alt_idle", 1'b0, 4'd0, 4'b1111, 32'd17, 1'b1);

    // reset mid-operation with holds 0 and 2 full and seven commands issued
    set_in(1'b0, 1'b1, 1'b0, 4'b0000); @(negedge clk);
    set_in(1'b1, 1'b1, 1'b0, 4'b0000); @(negedge clk);
    for (int g = 0; g < 7; g++) begin
      set_in(1'b1, 1'b1, 1'b0, 4'b0001); @(negedge clk);
      set_in(1'b1, 1'b1, 1'b0, 4'b0000); @(negedge clk);
    end
    chk("rst7/issued", 64'(issued), 64'd7);
    set_in(1'b1, 1'b1, 1'b1, 4'b0101); @(negedge clk);
    check_out("rst_full", 1'b0, 4'd0, 4'b1010, 32'd7, 1'b0);
    set_in(1'b0, 1'b1, 1'b1, 4'b0000); @(negedge clk);
    check_out("rst_hit", 1'b0, 4'd0, 4'b0000, 32'd0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      set_in(1'b1, 1'b1, 1'b0, 4'b0000); @(negedge clk);
      check_out($sformatf("rst_rel%0d", s), 1'b0, 4'd0, 4'b1111, 32'd0, 1'b1);
    end

    // random traffic against the model; requesters hold valid until accepted
    drv_v = 4'd0;
    for (int i = 0; i < NR; i++) pl[i] = '0;
    for (int c = 0; c < 3000; c++) begin
      rstn                  = ($urandom_range(0, 149) != 0);
      en                    = ($urandom_range(0, 7) != 0);
      bus.cmd_buf_alfull_in = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!drv_v[i] && ($urandom_range(0, 1) == 1)) begin
          drv_v[i] = 1'b1;
          pl[i]    = $urandom;
        end
        bus.req_payload_in[i*CW +: CW] = pl[i];
      end
      bus.req_valid_in = drv_v;
      acc = drv_v & m_rdy & {4{rstn}};
      @(negedge clk);
      drv_v = drv_v & ~acc;
      chk("rnd/valid",  64'(bus.command_valid_out), 64'(m_ov));
      chk("rnd/id",     64'(bus.command_id_out),    64'(m_oid));
      chk("rnd/payload",64'(bus.command_payload_out), 64'(m_opl));
      chk("rnd/ready",  64'(bus.req_ready_out),     64'(m_rdy));
      chk("rnd/issued", 64'(issued),                64'(m_cnt));
      chk("rnd/idle",   64'(idle),                  64'((m_hv == 4'd0) && !m_ov));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
